register_writeback_unit: RTL

- Writer side of the 32x32 register file: collects results from the single-cycle ALU pipe and the multi-cycle load unit.
- Arbitrates them onto the single register-file write port (write enable, write address, write data).
- Buffers load results in a small queue while the ALU holds the port.
- Keeps a pending-write scoreboard that the issue stage uses for load-use hazard stalls.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_load_queue.sv | 61 ++++++
 rtl/register_writeback_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register write-back unit.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LQ   = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/wb_load_queue.sv
// Load-result FIFO of wb_req_t entries; head is visible combinationally on pop_data.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    push_data,
    input  logic                       pop,
    output wb_req_t                    pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/register_writeback_unit.sv
// Arbitrates ALU and queued load results onto the register-file write port and tracks pending loads.
// Optional forwarding ports are enabled by defining REGISTER_WRITEBACK_BYPASS_EN.
module register_writeback_unit #(
    parameter int unsigned DATA_W   = wb_pkg::DATA_W,
    parameter int unsigned ADDR_W   = wb_pkg::ADDR_W,
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_dest,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_W-1:0]            ld_dest,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic                         iss_valid,
    input  logic [ADDR_W-1:0]            iss_dest,
`ifdef REGISTER_WRITEBACK_BYPASS_EN
    input  logic [ADDR_W-1:0]            byp_addr_a,
    input  logic [ADDR_W-1:0]            byp_addr_b,
    output logic                         byp_hit_a,
    output logic                         byp_hit_b,
    output logic [DATA_W-1:0]            byp_data_a,
    output logic [DATA_W-1:0]            byp_data_b,
`endif
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [(2**ADDR_W)-1:0]       pending,
    output logic [$clog2(LQ_DEPTH):0]    lq_count
);

    import wb_pkg::*;

    localparam int unsigned NREGS = 2**ADDR_W;

    logic                 ready_en_q;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [NREGS-1:0]     pending_q, pending_d;

    wb_sel_e              sel;
    wb_req_t              lq_in, lq_head;
    logic                 lq_push, lq_pop, lq_full, lq_empty;

    assign lq_in    = '{dest: ld_dest, data: ld_data};
    assign ld_ready = ready_en_q & ~lq_full;
    assign lq_push  = ld_valid & ld_ready;
    assign lq_pop   = (sel == SEL_LQ);

    wb_load_queue #(
        .DEPTH     (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data (lq_in),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .count     (lq_count),
        .full      (lq_full),
        .empty     (lq_empty)
    );

    // ALU always wins the port; the queue drains only in ALU-idle cycles.
    always_comb begin
        sel = SEL_NONE;
        if (alu_valid)      sel = SEL_ALU;
        else if (!lq_empty) sel = SEL_LQ;
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pending_d = pending_q;
        case (sel)
            SEL_ALU: begin
                wr_en_d   = (alu_dest != ADDR_W'(REG_ZERO));
                wr_addr_d = alu_dest;
                wr_data_d = alu_data;
            end
            SEL_LQ: begin
                wr_en_d   = (lq_head.dest != ADDR_W'(REG_ZERO));
                wr_addr_d = lq_head.dest;
                wr_data_d = lq_head.data;
                pending_d[lq_head.dest] = 1'b0;
            end
            default: ;
        endcase
        // A new issue to the same register outranks the retiring load.
        if (iss_valid) pending_d[iss_dest] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            pending_q  <= pending_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign pending = pending_q;

`ifdef REGISTER_WRITEBACK_BYPASS_EN
    // Forward the in-flight write; the file only shows it from the next cycle.
    assign byp_hit_a  = wr_en_q && (wr_addr_q == byp_addr_a) && (byp_addr_a != ADDR_W'(REG_ZERO));
    assign byp_hit_b  = wr_en_q && (wr_addr_q == byp_addr_b) && (byp_addr_b != ADDR_W'(REG_ZERO));
    assign byp_data_a = byp_hit_a ? wr_data_q : '0;
    assign byp_data_b = byp_hit_b ? wr_data_q : '0;
`endif

endmodule
